// File: rtl/conv_window_mac.sv
// Kernel-weighted dot product over a SIZE-tap window: two-stage pipeline (products, then sum) under a load/prime/run FSM.
// Optional CONV_MAC_SATURATE_EN clamps the sum to the signed DATA_WIDTH range and adds a sat_flag output.
module conv_window_mac #(
  parameter int SIZE       = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 66
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       weight_load,
  input  logic [DATA_WIDTH-1:0]      weight_in,
  input  logic                       window_valid,
  input  logic [SIZE*DATA_WIDTH-1:0] window_in,
  output logic                       kernel_ready,
  output logic                       run_active,
  output logic [ACC_WIDTH-1:0]       result,
  output logic                       result_valid
`ifdef CONV_MAC_SATURATE_EN
  , output logic                     sat_flag
`endif
);

  localparam int CW = $clog2(SIZE + 1);
  localparam int PW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    PRIME = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t                       state_r;
  logic [CW-1:0]                load_cnt_r;
  logic [CW-1:0]                prime_cnt_r;
  logic signed [DATA_WIDTH-1:0] kernel_r [SIZE];
  logic signed [DATA_WIDTH-1:0] slot_s   [SIZE];
  logic signed [PW-1:0]         prod_r   [SIZE];
  logic                         prod_valid_r;
  logic                         fire_s;
  logic signed [ACC_WIDTH-1:0]  sum_s;
  logic signed [ACC_WIDTH-1:0]  res_s;
`ifdef CONV_MAC_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  logic sat_s;
`endif

  // Control FSM: kernel load, window priming, streaming; status outputs registered with the state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      load_cnt_r   <= '0;
      prime_cnt_r  <= '0;
      kernel_ready <= 1'b0;
      run_active   <= 1'b0;
      for (int i = 0; i < SIZE; i++) kernel_r[i] <= '0;
    end else if (clear) begin
      state_r      <= IDLE;
      load_cnt_r   <= '0;
      prime_cnt_r  <= '0;
      kernel_ready <= 1'b0;
      run_active   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (weight_load) begin
            kernel_r[0] <= weight_in;
            load_cnt_r  <= CW'(1);
            if (SIZE == 1) begin
              state_r      <= RUN;
              kernel_ready <= 1'b1;
              run_active   <= 1'b1;
            end else begin
              state_r <= LOAD;
            end
          end
        end
        LOAD: begin
          if (weight_load) begin
            for (int i = 0; i < SIZE; i++) begin
              if (load_cnt_r == CW'(i)) kernel_r[i] <= weight_in;
            end
            load_cnt_r <= load_cnt_r + CW'(1);
            if (load_cnt_r == CW'(SIZE - 1)) begin
              state_r      <= PRIME;
              prime_cnt_r  <= '0;
              kernel_ready <= 1'b1;
            end
          end
        end
        // The (SIZE-1)th window completes the fill; the next one is the first full window.
        PRIME: begin
          if (window_valid) begin
            prime_cnt_r <= prime_cnt_r + CW'(1);
            if (prime_cnt_r == CW'(SIZE - 2)) begin
              state_r    <= RUN;
              run_active <= 1'b1;
            end
          end
        end
        RUN: begin
          state_r <= RUN;
        end
        default: begin
          state_r      <= IDLE;
          kernel_ready <= 1'b0;
          run_active   <= 1'b0;
        end
      endcase
    end
  end

  assign fire_s = window_valid && (state_r == RUN);

  // Unpack the flattened window bus into signed slots.
  always_comb begin
    for (int i = 0; i < SIZE; i++) slot_s[i] = window_in[DATA_WIDTH*i +: DATA_WIDTH];
  end

  // Stage 1: registered per-tap products.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prod_valid_r <= 1'b0;
      for (int i = 0; i < SIZE; i++) prod_r[i] <= '0;
    end else if (clear) begin
      prod_valid_r <= 1'b0;
    end else if (fire_s) begin
      prod_valid_r <= 1'b1;
      for (int i = 0; i < SIZE; i++) prod_r[i] <= PW'(kernel_r[i]) * PW'(slot_s[i]);
    end else begin
      prod_valid_r <= 1'b0;
    end
  end

  // Sign-extended sum of the products.
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < SIZE; i++) sum_s = sum_s + ACC_WIDTH'(prod_r[i]);
  end

  // Optional clamp to the signed DATA_WIDTH range.
  always_comb begin
`ifdef CONV_MAC_SATURATE_EN
    if (sum_s > SAT_MAX) begin
      res_s = SAT_MAX;
      sat_s = 1'b1;
    end else if (sum_s < SAT_MIN) begin
      res_s = SAT_MIN;
      sat_s = 1'b1;
    end else begin
      res_s = sum_s;
      sat_s = 1'b0;
    end
`else
    res_s = sum_s;
`endif
  end

  // Stage 2: registered result; result holds when no new sum arrives.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result       <= '0;
      result_valid <= 1'b0;
`ifdef CONV_MAC_SATURATE_EN
      sat_flag     <= 1'b0;
`endif
    end else if (clear) begin
      result_valid <= 1'b0;
`ifdef CONV_MAC_SATURATE_EN
      sat_flag     <= 1'b0;
`endif
    end else if (prod_valid_r) begin
      result       <= res_s;
      result_valid <= 1'b1;
`ifdef CONV_MAC_SATURATE_EN
      sat_flag     <= sat_s;
`endif
    end else begin
      result_valid <= 1'b0;
`ifdef CONV_MAC_SATURATE_EN
      sat_flag     <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_conv_window_mac.sv
// Scoreboard bench for conv_window_mac (SIZE=3, DATA_WIDTH=8, ACC_WIDTH=18): stimulus pushes expected dot products,
// a negedge monitor pops them when result_valid is seen.
module tb_conv_window_mac;

  localparam int SIZE = 3;
  localparam int DW   = 8;
  localparam int AW   = 18;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             clear = 1'b0;
  logic             weight_load = 1'b0;
  logic [DW-1:0]    weight_in = '0;
  logic             window_valid = 1'b0;
  logic [SIZE*DW-1:0] window_in = '0;
  logic             kernel_ready;
  logic             run_active;
  logic [AW-1:0]    result;
  logic             result_valid;
`ifdef CONV_MAC_SATURATE_EN
  logic             sat_flag;
`endif

  typedef struct {
    longint val;
    bit     sat;
    int     idx;
  } exp_t;

  exp_t   sb[$];
  int     n_vec = 0;
  int     n_err = 0;
  int     edge_cnt = 0;
  int     nloaded = 0;
  int     nwin = 0;
  longint wgt[SIZE];

  conv_window_mac #(.SIZE(SIZE), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .weight_load(weight_load), .weight_in(weight_in),
    .window_valid(window_valid), .window_in(window_in),
    .kernel_ready(kernel_ready), .run_active(run_active),
    .result(result), .result_valid(result_valid)
`ifdef CONV_MAC_SATURATE_EN
    , .sat_flag(sat_flag)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [SIZE*DW-1:0] pack3(input int s0, input int s1, input int s2);
    return {DW'(s2), DW'(s1), DW'(s0)};
  endfunction

  // Reference: plain integer dot product, optionally clamped to the 8-bit signed range.
  function automatic exp_t model(input logic [SIZE*DW-1:0] win, input int idx);
    exp_t   e;
    logic signed [DW-1:0] s;
    longint acc = 0;
    for (int i = 0; i < SIZE; i++) begin
      s = win[DW*i +: DW];
      acc += wgt[i] * longint'(s);
    end
    e.sat = 1'b0;
`ifdef CONV_MAC_SATURATE_EN
    if (acc > 127) begin acc = 127; e.sat = 1'b1; end
    else if (acc < -128) begin acc = -128; e.sat = 1'b1; end
`endif
    e.val = acc;
    e.idx = idx;
    return e;
  endfunction

  task automatic tick();
    @(posedge clock);
    edge_cnt++;
    #1;
    check("kernel_ready", longint'(kernel_ready), longint'(nloaded == SIZE));
    check("run_active", longint'(run_active), longint'(nloaded == SIZE && nwin >= SIZE - 1));
  endtask

  // One clock of stimulus; the model state before the edge decides what the cycle means.
  task automatic drive(input bit wl, input logic [DW-1:0] w, input bit wv,
                       input logic [SIZE*DW-1:0] win, input bit clr);
    int m;
    m = edge_cnt + 1;
    weight_load = wl; weight_in = w; window_valid = wv; window_in = win; clear = clr;
    if (clr) begin
      while (sb.size() > 0 && sb[sb.size()-1].idx >= m - 1) void'(sb.pop_back());
      nloaded = 0;
      nwin = 0;
    end else if (nloaded < SIZE) begin
      if (wl) begin
        wgt[nloaded] = longint'($signed(w));
        nloaded++;
      end
    end else if (wv) begin
      if (nwin < SIZE - 1) nwin++;
      else sb.push_back(model(win, m));
    end
    tick();
    weight_load = 1'b0; window_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic load(input int v);
    drive(1'b1, DW'(v), 1'b0, '0, 1'b0);
  endtask

  task automatic win3(input int s0, input int s1, input int s2);
    drive(1'b0, '0, 1'b1, pack3(s0, s1, s2), 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_clear();
    drive(1'b0, '0, 1'b0, '0, 1'b1);
  endtask

  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_result", longint'(result), 0);
    check("rst_result_valid", longint'(result_valid), 0);
    check("rst_kernel_ready", longint'(kernel_ready), 0);
    check("rst_run_active", longint'(run_active), 0);
    sb.delete();
    nloaded = 0;
    nwin = 0;
    tick();
    reset = 1'b1;
  endtask

  // Monitor: every result_valid must match the oldest outstanding expectation.
  always @(negedge clock) begin
    exp_t e;
    if (reset && result_valid) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("result", longint'($signed(result)), e.val);
`ifdef CONV_MAC_SATURATE_EN
        check("sat_flag", longint'(sat_flag), longint'(e.sat));
`endif
      end else begin
        n_vec++;
        n_err++;
        $display("FAIL stray_result_valid: got result_valid=1 result=%0d, expected no result (t=%0t)",
                 $signed(result), $time);
      end
    end
  end

  initial begin
    bit wl, wv, clr;
    #3;
    check("init_result", longint'(result), 0);
    check("init_result_valid", longint'(result_valid), 0);
    check("init_kernel_ready", longint'(kernel_ready), 0);
    check("init_run_active", longint'(run_active), 0);
    tick();
    reset = 1'b1;
    idle(2);

    // Load and prime, then the first full window.
    load(1); load(2); load(3);
    win3(1, 0, 0); win3(2, 1, 0);
    win3(3, 2, 1);
    idle(3);

    // Back-to-back streaming.
    win3(1, 1, 1); win3(-1, -1, -1); win3(0, 0, 0); win3(127, 127, 127);
    idle(3);

    // Extreme negative operands.
    do_clear();
    load(-128); load(-128); load(-128);
    win3(5, 6, 7); win3(-3, 4, 9);
    win3(-128, -128, -128);
    idle(3);

    // Saturation vectors (full precision in the default build).
    do_clear();
    load(127); load(127); load(127);
    win3(0, 0, 0); win3(0, 0, 0);
    win3(127, 127, 127); win3(1, 0, 0);
    idle(3);

    // clear on the cycle after a RUN window: the result must never appear.
    win3(9, 8, 7);
    do_clear();
    win3(1, 2, 3); win3(4, 5, 6); win3(7, 8, 9);
    load(2); load(-1); load(4);
    win3(1, 1, 1); win3(2, 2, 2);
    win3(3, -4, 5); win3(-6, 7, -8);
    idle(3);

    // Asynchronous reset after two of three weights.
    do_clear();
    load(10); load(20);
    async_reset();
    load(3); load(-5);
    win3(1, 1, 1);
    load(7);
    win3(1, 2, 3); win3(1, 2, 3);
    win3(4, -2, 6);
    idle(3);

    // Randomized mix of loads, windows and occasional clears.
    for (int n = 0; n < 400; n++) begin
      clr = ($urandom_range(0, 99) < 2);
      wl  = ($urandom_range(0, 2) == 0);
      wv  = ($urandom_range(0, 3) != 0);
      drive(wl, DW'($urandom()), wv, (SIZE*DW)'($urandom()), clr);
    end
    idle(4);
    check("scoreboard_drained", longint'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
